// File: rtl/alu_sched.sv
// alu_sched -- sequencer for the stereo reverb/filter ALU.
//
// On each new sample pair, walks the 16 Rj groups of the left channel and
// then the right channel. Every group loads a tap count u_limit from the Rj
// memory, issues that many MACs, then shifts the accumulator once. A
// result strobe goes out after the 16th shift of each channel.
//
// Ports
//   clk           system clock, rising edge
//   clear_n       asynchronous active-low reset
//   frame_valid   one-cycle pulse: new L/R sample pair available
//   cur_addr      data-memory address of the newest sample (with frame_valid)
//   stall         freezes the sequencer; all strobes forced low
//   rj_data       Rj memory read data (combinational from rj_addr)
//   coeff_data    coefficient word: [8] sign, [7:0] delay
//   rj_addr       {chan, rj_idx}
//   coeff_addr    {chan, coeff_idx}
//   data_addr     cur_addr_q - delay, modulo 256
//   acc_clr, acc_add_en, acc_sub, acc_shift_en   accumulator commands
//   out_valid     result for out_chan is ready (one cycle)
//   out_chan      0 = left, 1 = right
//   busy          sequencer not idle
//   overrun       sticky: a frame was dropped
//   coeff_ovf     sticky: a channel asked for more than 256 coefficients
//
// Build option
//   ALU_SCHED_FRAME_BUF_EN  adds a one-deep buffer for a frame arriving
//                           while busy; without it such frames are dropped.
//
// state | meaning
// IDLE  | waiting for a frame (or a buffered one)
// CLR   | clear accumulator, reset per-channel counters
// RJ    | load tap count for group rj_idx
// MAC   | one multiply-accumulate per cycle, u_limit times
// SHIFT | shift accumulator, advance to next group
// DONE  | publish result for chan, then right channel or idle
module alu_sched (
   input  logic        clk,
   input  logic        clear_n,
   input  logic        frame_valid,
   input  logic [7:0]  cur_addr,
   input  logic        stall,
   input  logic [7:0]  rj_data,
   input  logic [15:0] coeff_data,
   output logic [4:0]  rj_addr,
   output logic [8:0]  coeff_addr,
   output logic [7:0]  data_addr,
   output logic        acc_clr,
   output logic        acc_add_en,
   output logic        acc_sub,
   output logic        acc_shift_en,
   output logic        out_valid,
   output logic        out_chan,
   output logic        busy,
   output logic        overrun,
   output logic        coeff_ovf
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_RJ    = 3'd2,
      S_MAC   = 3'd3,
      S_SHIFT = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t      state;
   logic        chan;
   logic [3:0]  rj_idx;
   logic [7:0]  coeff_idx;
   logic [7:0]  u_cnt;
   logic [7:0]  u_limit;
   logic [7:0]  cur_addr_q;
   logic        coeff_spent;   // coefficient 255 already used this channel
   logic        overrun_q;
   logic        coeff_ovf_q;

   logic        run;
   logic        idle_go;
   logic        take_new;
   logic        take_pend;
   logic        start;
   logic [7:0]  start_addr;
   logic        unused_coeff_hi;

   assign run     = ~stall;
   assign idle_go = (state == S_IDLE) & run;
   assign start   = take_new | take_pend;

`ifdef ALU_SCHED_FRAME_BUF_EN
   logic       pending;
   logic [7:0] pend_addr;

   // A buffered frame has priority over one arriving in the same cycle;
   // the arriving one then refills the slot that is being emptied.
   assign take_pend  = idle_go & pending;
   assign take_new   = idle_go & ~pending & frame_valid;
   assign start_addr = pending ? pend_addr : cur_addr;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         pending   <= 1'b0;
         pend_addr <= 8'd0;
         overrun_q <= 1'b0;
      end else begin
         if (take_pend)
            pending <= 1'b0;
         if (frame_valid && !take_new) begin
            if (!pending || take_pend) begin
               pending   <= 1'b1;
               pend_addr <= cur_addr;
            end else begin
               overrun_q <= 1'b1;
            end
         end
      end
   end
`else
   assign take_pend  = 1'b0;
   assign take_new   = idle_go & frame_valid;
   assign start_addr = cur_addr;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n)
         overrun_q <= 1'b0;
      else if (frame_valid && !take_new)
         overrun_q <= 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state       <= S_IDLE;
         chan        <= 1'b0;
         rj_idx      <= 4'd0;
         coeff_idx   <= 8'd0;
         u_cnt       <= 8'd0;
         u_limit     <= 8'd0;
         cur_addr_q  <= 8'd0;
         coeff_spent <= 1'b0;
         coeff_ovf_q <= 1'b0;
      end else if (run) begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  cur_addr_q <= start_addr;
                  chan       <= 1'b0;
                  state      <= S_CLR;
               end
            end
            S_CLR: begin
               rj_idx      <= 4'd0;
               coeff_idx   <= 8'd0;
               u_cnt       <= 8'd0;
               coeff_spent <= 1'b0;
               state       <= S_RJ;
            end
            S_RJ: begin
               u_limit <= rj_data;
               state   <= (rj_data == 8'd0) ? S_SHIFT : S_MAC;
            end
            S_MAC: begin
               u_cnt <= u_cnt + 8'd1;
               // Index saturates at 255; later MACs of the channel are
               // sequenced but not accumulated.
               if (coeff_spent)
                  coeff_ovf_q <= 1'b1;
               else if (coeff_idx == 8'd255)
                  coeff_spent <= 1'b1;
               else
                  coeff_idx <= coeff_idx + 8'd1;
               if (u_cnt == u_limit - 8'd1)
                  state <= S_SHIFT;
            end
            S_SHIFT: begin
               u_cnt <= 8'd0;
               if (rj_idx == 4'd15) begin
                  state <= S_DONE;
               end else begin
                  rj_idx <= rj_idx + 4'd1;
                  state  <= S_RJ;
               end
            end
            S_DONE: begin
               if (!chan) begin
                  chan  <= 1'b1;
                  state <= S_CLR;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign rj_addr      = {chan, rj_idx};
   assign coeff_addr   = {chan, coeff_idx};
   assign data_addr    = cur_addr_q - coeff_data[7:0];

   assign acc_clr      = (state == S_CLR) & run;
   assign acc_add_en   = (state == S_MAC) & run & ~coeff_spent;
   assign acc_sub      = acc_add_en & coeff_data[8];
   assign acc_shift_en = (state == S_SHIFT) & run;
   assign out_valid    = (state == S_DONE) & run;
   assign out_chan     = chan;
   assign busy         = (state != S_IDLE);
   assign overrun      = overrun_q;
   assign coeff_ovf    = coeff_ovf_q;

   assign unused_coeff_hi = ^coeff_data[15:9];

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;

   logic        clk;
   logic        clear_n;
   logic        frame_valid;
   logic [7:0]  cur_addr;
   logic        stall;
   logic [7:0]  rj_data;
   logic [15:0] coeff_data;
   logic [4:0]  rj_addr;
   logic [8:0]  coeff_addr;
   logic [7:0]  data_addr;
   logic        acc_clr, acc_add_en, acc_sub, acc_shift_en;
   logic        out_valid, out_chan, busy, overrun, coeff_ovf;

   logic [7:0]  rj_mem    [0:31];
   logic [15:0] coeff_mem [0:511];

   assign rj_data    = rj_mem[rj_addr];
   assign coeff_data = coeff_mem[coeff_addr];

   alu_sched dut (
      .clk          (clk),
      .clear_n      (clear_n),
      .frame_valid  (frame_valid),
      .cur_addr     (cur_addr),
      .stall        (stall),
      .rj_data      (rj_data),
      .coeff_data   (coeff_data),
      .rj_addr      (rj_addr),
      .coeff_addr   (coeff_addr),
      .data_addr    (data_addr),
      .acc_clr      (acc_clr),
      .acc_add_en   (acc_add_en),
      .acc_sub      (acc_sub),
      .acc_shift_en (acc_shift_en),
      .out_valid    (out_valid),
      .out_chan     (out_chan),
      .busy         (busy),
      .overrun      (overrun),
      .coeff_ovf    (coeff_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] l_val, l0, l15, r_val, r0;
      int st_start, st_len;
      int exp_l, exp_r, exp_idle;
      int add_l, add_r, sub_l, sub_r;
      int exp_ovf;
   } vec_t;

   vec_t vecs [0:5];

   int   tot, npass;
   int   rel;
   int   ov_n;
   int   ov_cyc [0:7];
   logic ov_chan [0:7];
   int   add_c [0:1];
   int   sub_c [0:1];
   int   shf_c [0:1];
   int   clr_c [0:1];
   int   viol;
   int   busy_seen;

   task automatic chk(input string nm, input int act, input int exp);
      tot++;
      if (act == exp) npass++;
      else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
   endtask

   task automatic clear_counts();
      ov_n = 0;
      busy_seen = 0;
      for (int i = 0; i < 8; i++) begin
         ov_cyc[i]  = -1;
         ov_chan[i] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         add_c[i] = 0; sub_c[i] = 0; shf_c[i] = 0; clr_c[i] = 0;
      end
   endtask

   task automatic sample();
      int ch;
      int ns;
      ch = (ov_n == 0) ? 0 : 1;
      ns = int'(acc_clr) + int'(acc_add_en) + int'(acc_shift_en) + int'(out_valid);
      if (ns > 1) viol++;
      if (stall && ns != 0) viol++;
      if (acc_sub && !acc_add_en) viol++;
      if (acc_add_en) add_c[ch]++;
      if (acc_add_en && acc_sub) sub_c[ch]++;
      if (acc_shift_en) shf_c[ch]++;
      if (acc_clr) clr_c[ch]++;
      if (busy) busy_seen++;
      if (out_valid) begin
         if (ov_n < 8) begin
            ov_cyc[ov_n]  = rel;
            ov_chan[ov_n] = out_chan;
         end
         ov_n++;
      end
   endtask

   task automatic cyc_run(input logic fv, input logic st);
      @(posedge clk);
      #1;
      frame_valid = fv;
      stall       = st;
      rel++;
      @(negedge clk);
      sample();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      frame_valid = 1'b0;
      stall       = 1'b0;
      clear_n     = 1'b0;
      #2;
      chk("reset_state",
          int'({busy, overrun, coeff_ovf, acc_clr, acc_add_en, acc_shift_en,
                out_valid, rj_addr, coeff_addr}), 0);
      @(negedge clk);
      clear_n = 1'b1;
   endtask

   task automatic run_frame(input int st_start, input int st_len, output int idle_at);
      clear_counts();
      rel = -1;
      cyc_run(1'b1, 1'b0);
      idle_at = -1;
      for (int k = 0; k < 2000; k++) begin
         cyc_run(1'b0, (rel + 1 >= st_start) && (rel + 1 < st_start + st_len));
         if (!busy) begin
            idle_at = rel;
            break;
         end
      end
   endtask

   task automatic load_rj(input logic [7:0] l_val, input logic [7:0] l0,
                          input logic [7:0] l15, input logic [7:0] r_val,
                          input logic [7:0] r0);
      for (int i = 0; i < 16; i++) begin
         rj_mem[i]      = (i == 0) ? l0 : ((i == 15) ? l15 : l_val);
         rj_mem[16 + i] = (i == 0) ? r0 : r_val;
      end
   endtask

   task automatic load_coeff();
      logic [8:0] a;
      logic       sgn;
      for (int i = 0; i < 512; i++) begin
         a   = i[8:0];
         sgn = a[8] ? (a[1:0] == 2'b00) : a[0];
         coeff_mem[i] = {7'd0, sgn, a[7:0]};
      end
   endtask

   initial begin
      int idle_at;
      int ovr_mid;
      tot = 0; npass = 0; viol = 0; rel = 0;
      clear_n = 1'b0; frame_valid = 1'b0; stall = 1'b0; cur_addr = 8'h00;
      load_coeff();
      load_rj(8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
      clear_counts();

      //          l  l0  l15 r  r0  stall   L    R    idle  addL addR subL subR ovf
      vecs[0] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 0, 0,  50, 100, 101,  16, 16,   8,  4, 0};
      vecs[1] = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 0, 0,  49,  98,  99,  15, 15,   7,  4, 0};
      vecs[2] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 0, 0,  66, 132, 133,  32, 32,  16,  8, 0};
      vecs[3] = '{8'd19, 8'd19, 8'd15, 8'd1, 8'd1, 0, 0, 334, 384, 385, 256, 16, 128,  4, 1};
      vecs[4] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0,  34,  68,  69,   0,  0,   0,  0, 0};
      vecs[5] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 12, 5, 55, 105, 106,  16, 16,   8,  4, 0};

      for (int v = 0; v < 6; v++) begin
         load_rj(vecs[v].l_val, vecs[v].l0, vecs[v].l15, vecs[v].r_val, vecs[v].r0);
         do_reset();
         cur_addr = 8'h40;
         run_frame(vecs[v].st_start, vecs[v].st_len, idle_at);
         chk($sformatf("v%0d_out_count", v), ov_n, 2);
         chk($sformatf("v%0d_l_out_cycle", v), ov_cyc[0], vecs[v].exp_l);
         chk($sformatf("v%0d_r_out_cycle", v), ov_cyc[1], vecs[v].exp_r);
         chk($sformatf("v%0d_idle_cycle", v), idle_at, vecs[v].exp_idle);
         chk($sformatf("v%0d_chan_order", v), int'({ov_chan[0], ov_chan[1]}), 1);
         chk($sformatf("v%0d_add_l", v), add_c[0], vecs[v].add_l);
         chk($sformatf("v%0d_add_r", v), add_c[1], vecs[v].add_r);
         chk($sformatf("v%0d_sub_l", v), sub_c[0], vecs[v].sub_l);
         chk($sformatf("v%0d_sub_r", v), sub_c[1], vecs[v].sub_r);
         chk($sformatf("v%0d_shift_l", v), shf_c[0], 16);
         chk($sformatf("v%0d_shift_r", v), shf_c[1], 16);
         chk($sformatf("v%0d_clr_lr", v), clr_c[0] * 10 + clr_c[1], 11);
         chk($sformatf("v%0d_coeff_ovf", v), int'(coeff_ovf), vecs[v].exp_ovf);
         chk($sformatf("v%0d_overrun", v), int'(overrun), 0);
      end

      // data_addr / acc_sub for hand-set coefficients
      load_rj(8'd1, 8'd1, 8'd1, 8'd1, 8'd1);
      coeff_mem[0] = 16'h0105;
      do_reset();
      clear_counts();
      cur_addr = 8'h03;
      rel = -1;
      cyc_run(1'b1, 1'b0);
      for (int k = 0; k < 3; k++) cyc_run(1'b0, 1'b0);
      chk("mac0_data_addr", int'(data_addr), 8'hFE);
      chk("mac0_add_sub", int'({acc_add_en, acc_sub}), 3);
      for (int k = 0; k < 3; k++) cyc_run(1'b0, 1'b0);
      chk("mac1_add_sub_addr", int'({acc_add_en, acc_sub, data_addr}), int'({2'b11, 8'h02}));
      for (int k = 0; k < 200 && busy; k++) cyc_run(1'b0, 1'b0);
      chk("hand_frame_idle", int'(busy), 0);
      coeff_mem[0] = 16'h0000;

      // reset in the middle of a frame
      do_reset();
      clear_counts();
      rel = -1;
      cyc_run(1'b1, 1'b0);
      for (int k = 0; k < 20; k++) cyc_run(1'b0, 1'b0);
      #2;
      clear_n = 1'b0;
      #1;
      chk("midreset_async", int'({busy, rj_addr, coeff_addr}), 0);
      @(negedge clk);
      clear_n = 1'b1;
      clear_counts();
      for (int k = 0; k < 120; k++) cyc_run(1'b0, 1'b0);
      chk("midreset_no_out", ov_n, 0);
      chk("midreset_no_busy", busy_seen, 0);

      // frames arriving while busy
      do_reset();
      clear_counts();
      cur_addr = 8'h10;
      ovr_mid = -1;
      rel = -1;
      cyc_run(1'b1, 1'b0);
      while (rel < 230) begin
         cyc_run((rel + 1 == 20) || (rel + 1 == 30), 1'b0);
         if (rel == 25) ovr_mid = int'(overrun);
      end
`ifdef ALU_SCHED_FRAME_BUF_EN
      chk("buf_out_count", ov_n, 4);
      chk("buf_l2_cycle", ov_cyc[2], 151);
      chk("buf_r2_cycle", ov_cyc[3], 201);
      chk("buf_overrun_mid", ovr_mid, 0);
`else
      chk("nobuf_out_count", ov_n, 2);
      chk("nobuf_r1_cycle", ov_cyc[1], 100);
      chk("nobuf_overrun_mid", ovr_mid, 1);
`endif
      chk("busy_frames_overrun", int'(overrun), 1);
      chk("busy_frames_idle", int'(busy), 0);

      chk("strobe_rule_violations", viol, 0);

      $display("%0d/%0d checks passed", npass, tot);
      $finish;
   end

endmodule
